// File: rtl/mips_pkg.sv
// Shared constants, control-bundle layout and watchdog encoding for the
// pipeline stage controller.
package mips_pkg;

  localparam int          CTRL_W          = 10;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int          STALL_LIMIT_DEF = 64;

  // Bit offsets within the decoded control bundle (ALU control is 3 bits wide).
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 5;
  localparam int CTRL_JUMP      = 6;
  localparam int CTRL_ALUCTL_LO = 7;
  localparam int CTRL_ALUCTL_W  = 3;

  typedef enum logic [1:0] {
    WD_RUN   = 2'd0,
    WD_STALL = 2'd1,
    WD_HUNG  = 2'd2
  } wd_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Fetch/decode/execute pipeline bundle between the hazard/datapath logic
// (master) and the stage controller (slave).
interface pipe_stage_ctrl_if
  import mips_pkg::*;
#(
  parameter int CTRL_W = mips_pkg::CTRL_W
);
  logic              stallF, stallD, flushD, flushE;
  logic [31:0]       pcnextF, pcF;
  logic [31:0]       instrF, pcplus4F, instrD, pcplus4D;
  logic              validD, validE;
  logic [CTRL_W-1:0] ctrlD, ctrlE;
  logic [31:0]       rd1D, rd2D, signimmD, rd1E, rd2E, signimmE;
  logic [4:0]        rsD, rtD, rdD, rsE, rtE, rdE;
  logic [15:0]       stall_cnt, bubble_cnt;
  logic              stall_err;

  modport master (
    output stallF, stallD, flushD, flushE, pcnextF, instrF, pcplus4F,
           ctrlD, rd1D, rd2D, signimmD, rsD, rtD, rdD,
    input  pcF, instrD, pcplus4D, validD, ctrlE, rd1E, rd2E, signimmE,
           rsE, rtE, rdE, validE, stall_cnt, bubble_cnt, stall_err
  );

  modport slave (
    input  stallF, stallD, flushD, flushE, pcnextF, instrF, pcplus4F,
           ctrlD, rd1D, rd2D, signimmD, rsD, rtD, rdD,
    output pcF, instrD, pcplus4D, validD, ctrlE, rd1E, rd2E, signimmE,
           rsE, rtE, rdE, validE, stall_cnt, bubble_cnt, stall_err
  );
endinterface

// File: rtl/flopenrc.sv
// Pipeline register: async active-low reset, enable, and a synchronous clear
// that only takes effect on enabled edges.
module flopenrc #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_q <= RST_VAL;
    else if (i_en) o_q <= i_clr ? '0 : i_d;
  end
endmodule

// File: rtl/pipe_stage_ctrl.sv
// PC, F/D and D/E pipeline registers with stall/flush control, saturating
// performance counters and a stall watchdog with a sticky error flag.
module pipe_stage_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int          CTRL_W      = mips_pkg::CTRL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_stage_ctrl_if.slave bus
);
  localparam int          FD_W  = 1 + 32 + 32;
  localparam int          DE_W  = 1 + CTRL_W + 3*32 + 3*5;
  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

  logic [FD_W-1:0] w_fd_d, w_fd_q;
  logic [DE_W-1:0] w_de_d, w_de_q;

  flopenrc #(.WIDTH(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.stallF), .i_clr(1'b0),
    .i_d(bus.pcnextF), .o_q(bus.pcF)
  );

  // Stall wins over flush because the clear is only applied when enabled.
  assign w_fd_d = {1'b1, bus.instrF, bus.pcplus4F};
  flopenrc #(.WIDTH(FD_W)) u_fd (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.stallD), .i_clr(bus.flushD),
    .i_d(w_fd_d), .o_q(w_fd_q)
  );
  assign {bus.validD, bus.instrD, bus.pcplus4D} = w_fd_q;

  assign w_de_d = {bus.validD, bus.ctrlD, bus.rd1D, bus.rd2D, bus.signimmD,
                   bus.rsD, bus.rtD, bus.rdD};
  flopenrc #(.WIDTH(DE_W)) u_de (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(bus.flushE),
    .i_d(w_de_d), .o_q(w_de_q)
  );
  assign {bus.validE, bus.ctrlE, bus.rd1E, bus.rd2E, bus.signimmE,
          bus.rsE, bus.rtE, bus.rdE} = w_de_q;

  logic [15:0] r_stall_cnt, r_bubble_cnt;
  logic        w_bubble;

  // A cycle that flushes both stages is still a single bubble.
  assign w_bubble = bus.flushE | (bus.flushD & ~bus.stallD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (bus.stallD) r_stall_cnt  <= sat_inc16(r_stall_cnt);
      if (w_bubble)   r_bubble_cnt <= sat_inc16(r_bubble_cnt);
    end
  end

  wd_state_e   r_state, w_state_nxt;
  logic [15:0] r_run_cnt, w_run_nxt, w_run_inc;
  logic        r_stall_err, w_proto;

  assign w_run_inc = r_run_cnt + 16'd1;
  assign w_proto   = bus.stallD & ~bus.stallF;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    case (r_state)
      WD_RUN: begin
        if (bus.stallD) begin
          w_state_nxt = WD_STALL;
          w_run_nxt   = 16'd1;
        end
      end
      WD_STALL: begin
        if (bus.stallD) begin
          w_run_nxt = w_run_inc;
          if (w_run_inc == LIMIT) w_state_nxt = WD_HUNG;
        end else begin
          w_state_nxt = WD_RUN;
          w_run_nxt   = '0;
        end
      end
      WD_HUNG: ;
      default: w_state_nxt = WD_HUNG;
    endcase
    // Stalling decode while fetch advances loses an instruction.
    if (w_proto) w_state_nxt = WD_HUNG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WD_RUN;
      r_run_cnt   <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_cnt   <= w_run_nxt;
      r_stall_err <= (w_state_nxt == WD_HUNG);
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.stall_err  = r_stall_err;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl; watchdog limit shortened to 4 stalls.
module tb_pipe_stage_ctrl;
  import mips_pkg::*;

  localparam logic [31:0] T_RESET_PC    = 32'h0000_0000;
  localparam int          T_STALL_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  pipe_stage_ctrl_if #(.CTRL_W(CTRL_W)) bus ();

  pipe_stage_ctrl #(
    .RESET_PC(T_RESET_PC), .STALL_LIMIT(T_STALL_LIMIT), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stallF = 1'b0; bus.stallD = 1'b0; bus.flushD = 1'b0; bus.flushE = 1'b0;
    bus.pcnextF = '0; bus.instrF = '0; bus.pcplus4F = '0;
    bus.ctrlD = '0; bus.rd1D = '0; bus.rd2D = '0; bus.signimmD = '0;
    bus.rsD = '0; bus.rtD = '0; bus.rdD = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.pcF !== T_RESET_PC) $display("FAIL rst_pc: got %h want %h", bus.pcF, T_RESET_PC); else n_pass++;
    n_total++; if (bus.validD !== 1'b0) $display("FAIL rst_validD: got %b want 0", bus.validD); else n_pass++;
    n_total++; if (bus.validE !== 1'b0) $display("FAIL rst_validE: got %b want 0", bus.validE); else n_pass++;
    n_total++; if (bus.instrD !== 32'h0) $display("FAIL rst_instrD: got %h want 0", bus.instrD); else n_pass++;
    n_total++; if (bus.ctrlE !== '0) $display("FAIL rst_ctrlE: got %h want 0", bus.ctrlE); else n_pass++;
    n_total++; if (bus.stall_cnt !== 16'h0) $display("FAIL rst_stall_cnt: got %h want 0", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'h0) $display("FAIL rst_bubble_cnt: got %h want 0", bus.bubble_cnt); else n_pass++;
    n_total++; if (bus.stall_err !== 1'b0) $display("FAIL rst_stall_err: got %b want 0", bus.stall_err); else n_pass++;
    bus.pcnextF = 32'h10;
    tick();
    n_total++; if (bus.pcF !== T_RESET_PC) $display("FAIL rst_hold_pc: got %h want %h", bus.pcF, T_RESET_PC); else n_pass++;
  endtask

  task automatic test_release();
    bus.pcnextF  = 32'h4;
    bus.instrF   = 32'h2002_0005;
    bus.pcplus4F = 32'h4;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.pcF !== 32'h0) $display("FAIL rel_pc0: got %h want 0", bus.pcF); else n_pass++;
    tick();
    n_total++; if (bus.pcF !== 32'h4) $display("FAIL rel_pc1: got %h want 4", bus.pcF); else n_pass++;
    n_total++; if (bus.instrD !== 32'h2002_0005) $display("FAIL rel_instrD: got %h want 20020005", bus.instrD); else n_pass++;
    n_total++; if (bus.validE !== 1'b0) $display("FAIL rel_validE1: got %b want 0", bus.validE); else n_pass++;
    tick();
    n_total++; if (bus.validD !== 1'b1) $display("FAIL rel_validD2: got %b want 1", bus.validD); else n_pass++;
    n_total++; if (bus.validE !== 1'b1) $display("FAIL rel_validE2: got %b want 1", bus.validE); else n_pass++;
  endtask

  task automatic test_payload();
    bus.ctrlD = 10'h2A5; bus.rd1D = 32'hDEAD_BEEF; bus.rd2D = 32'h1234_5678;
    bus.signimmD = 32'hFFFF_FFF0; bus.rsD = 5'd3; bus.rtD = 5'd17; bus.rdD = 5'd31;
    tick();
    n_total++; if (bus.ctrlE !== 10'h2A5) $display("FAIL de_ctrlE: got %h want 2a5", bus.ctrlE); else n_pass++;
    n_total++; if (bus.rd1E !== 32'hDEAD_BEEF) $display("FAIL de_rd1E: got %h want deadbeef", bus.rd1E); else n_pass++;
    n_total++; if (bus.rd2E !== 32'h1234_5678) $display("FAIL de_rd2E: got %h want 12345678", bus.rd2E); else n_pass++;
    n_total++; if (bus.signimmE !== 32'hFFFF_FFF0) $display("FAIL de_signimmE: got %h want fffffff0", bus.signimmE); else n_pass++;
    n_total++; if ({bus.rsE, bus.rtE, bus.rdE} !== {5'd3, 5'd17, 5'd31}) $display("FAIL de_regs: got %0d/%0d/%0d want 3/17/31", bus.rsE, bus.rtE, bus.rdE); else n_pass++;
    bus.flushE = 1'b1;
    tick();
    bus.flushE = 1'b0;
    n_total++; if (bus.ctrlE !== '0) $display("FAIL fe_ctrlE: got %h want 0", bus.ctrlE); else n_pass++;
    n_total++; if (bus.rd1E !== 32'h0) $display("FAIL fe_rd1E: got %h want 0", bus.rd1E); else n_pass++;
    n_total++; if (bus.rdE !== 5'd0) $display("FAIL fe_rdE: got %0d want 0", bus.rdE); else n_pass++;
    n_total++; if (bus.validE !== 1'b0) $display("FAIL fe_validE: got %b want 0", bus.validE); else n_pass++;
    n_total++; if (bus.validD !== 1'b1) $display("FAIL fe_validD: got %b want 1", bus.validD); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'd1) $display("FAIL fe_bubble: got %0d want 1", bus.bubble_cnt); else n_pass++;
  endtask

  task automatic test_stall_flush();
    apply_reset();
    bus.pcnextF = 32'h8; bus.instrF = 32'h8C01_0004; bus.pcplus4F = 32'h8;
    tick();
    bus.stallF = 1'b1; bus.stallD = 1'b1; bus.flushE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pcnextF = 32'hC + 32'(i); bus.instrF = 32'hFFFF_FFF0 + 32'(i);
      tick();
    end
    n_total++; if (bus.pcF !== 32'h8) $display("FAIL sf_pc: got %h want 8", bus.pcF); else n_pass++;
    n_total++; if (bus.instrD !== 32'h8C01_0004) $display("FAIL sf_instrD: got %h want 8c010004", bus.instrD); else n_pass++;
    n_total++; if (bus.validE !== 1'b0) $display("FAIL sf_validE: got %b want 0", bus.validE); else n_pass++;
    n_total++; if (bus.stall_cnt !== 16'd3) $display("FAIL sf_stall_cnt: got %0d want 3", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'd3) $display("FAIL sf_bubble_cnt: got %0d want 3", bus.bubble_cnt); else n_pass++;
    bus.stallF = 1'b0; bus.stallD = 1'b0; bus.flushE = 1'b0; bus.pcnextF = 32'h30;
    tick();
    n_total++; if (bus.pcF !== 32'h30) $display("FAIL sf_resume_pc: got %h want 30", bus.pcF); else n_pass++;
    n_total++; if (bus.stall_err !== 1'b0) $display("FAIL sf_no_err: got %b want 0", bus.stall_err); else n_pass++;
  endtask

  task automatic test_stall_priority();
    apply_reset();
    bus.pcnextF = 32'h4; bus.instrF = 32'h1111_2222; bus.pcplus4F = 32'h4;
    tick();
    bus.stallF = 1'b1; bus.stallD = 1'b1; bus.flushD = 1'b1; bus.instrF = 32'h3333_4444;
    tick();
    n_total++; if (bus.instrD !== 32'h1111_2222) $display("FAIL sp_instrD: got %h want 11112222", bus.instrD); else n_pass++;
    n_total++; if (bus.validD !== 1'b1) $display("FAIL sp_validD: got %b want 1", bus.validD); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'd0) $display("FAIL sp_bubble0: got %0d want 0", bus.bubble_cnt); else n_pass++;
    bus.stallF = 1'b0; bus.stallD = 1'b0;
    tick();
    n_total++; if (bus.instrD !== 32'h0) $display("FAIL fd_instrD: got %h want 0", bus.instrD); else n_pass++;
    n_total++; if (bus.pcplus4D !== 32'h0) $display("FAIL fd_pcplus4D: got %h want 0", bus.pcplus4D); else n_pass++;
    n_total++; if (bus.validD !== 1'b0) $display("FAIL fd_validD: got %b want 0", bus.validD); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'd1) $display("FAIL fd_bubble1: got %0d want 1", bus.bubble_cnt); else n_pass++;
    bus.flushE = 1'b1;
    tick();
    n_total++; if (bus.bubble_cnt !== 16'd2) $display("FAIL both_flush_bubble: got %0d want 2", bus.bubble_cnt); else n_pass++;
    bus.flushD = 1'b0; bus.flushE = 1'b0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    bus.stallF = 1'b1; bus.stallD = 1'b1;
    repeat (3) tick();
    n_total++; if (bus.stall_err !== 1'b0) $display("FAIL wd_before: got %b want 0", bus.stall_err); else n_pass++;
    tick();
    n_total++; if (bus.stall_err !== 1'b1) $display("FAIL wd_trip: got %b want 1", bus.stall_err); else n_pass++;
    bus.stallF = 1'b0; bus.stallD = 1'b0; bus.pcnextF = 32'h40;
    repeat (2) tick();
    n_total++; if (bus.stall_err !== 1'b1) $display("FAIL wd_sticky: got %b want 1", bus.stall_err); else n_pass++;
    n_total++; if (bus.pcF !== 32'h40) $display("FAIL wd_pc_runs: got %h want 40", bus.pcF); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.stall_err !== 1'b0) $display("FAIL wd_reset_clear: got %b want 0", bus.stall_err); else n_pass++;
  endtask

  task automatic test_protocol();
    apply_reset();
    bus.pcnextF = 32'h20; bus.instrF = 32'hAAAA_0001;
    tick();
    bus.stallD = 1'b1; bus.stallF = 1'b0; bus.pcnextF = 32'h24; bus.instrF = 32'hBBBB_0002;
    tick();
    n_total++; if (bus.stall_err !== 1'b1) $display("FAIL proto_err: got %b want 1", bus.stall_err); else n_pass++;
    n_total++; if (bus.pcF !== 32'h24) $display("FAIL proto_pc: got %h want 24", bus.pcF); else n_pass++;
    n_total++; if (bus.instrD !== 32'hAAAA_0001) $display("FAIL proto_instrD: got %h want aaaa0001", bus.instrD); else n_pass++;
    bus.stallD = 1'b0;
    tick();
    n_total++; if (bus.stall_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", bus.stall_err); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    bus.pcnextF = 32'h100; bus.instrF = 32'hCAFE_0000;
    tick();
    bus.stallF = 1'b1; bus.stallD = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.stall_cnt !== 16'd0) $display("FAIL mid_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.pcF !== T_RESET_PC) $display("FAIL mid_pc: got %h want %h", bus.pcF, T_RESET_PC); else n_pass++;
    n_total++; if (bus.instrD !== 32'h0) $display("FAIL mid_instrD: got %h want 0", bus.instrD); else n_pass++;
    rst_n = 1'b1;
    repeat (3) tick();
    n_total++; if (bus.stall_cnt !== 16'd3) $display("FAIL mid_restall_cnt: got %0d want 3", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.stall_err !== 1'b0) $display("FAIL mid_wd_cleared: got %b want 0", bus.stall_err); else n_pass++;
    n_total++; if (bus.pcF !== T_RESET_PC) $display("FAIL mid_pc_held: got %h want %h", bus.pcF, T_RESET_PC); else n_pass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.r_stall_cnt = 16'hFFFE;
    force dut.r_bubble_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    release dut.r_bubble_cnt;
    n_total++; if (bus.stall_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", bus.stall_cnt); else n_pass++;
    bus.stallF = 1'b1; bus.stallD = 1'b1; bus.flushE = 1'b1;
    tick();
    n_total++; if (bus.stall_cnt !== 16'hFFFF) $display("FAIL sat_stall1: got %h want ffff", bus.stall_cnt); else n_pass++;
    repeat (2) tick();
    n_total++; if (bus.stall_cnt !== 16'hFFFF) $display("FAIL sat_stall3: got %h want ffff", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.bubble_cnt !== 16'hFFFF) $display("FAIL sat_bubble: got %h want ffff", bus.bubble_cnt); else n_pass++;
    idle();
  endtask

  initial begin
    test_reset();
    test_release();
    test_payload();
    test_stall_flush();
    test_stall_priority();
    test_watchdog();
    test_protocol();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
